// File: rtl/serial_subtractor64.sv
// Multi-cycle 64-bit subtractor: one DIGIT_W-bit chunk per clock,
// LSB chunk first, with a registered borrow between chunks.
module serial_subtractor64 #(
  parameter int DIGIT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff,
  output logic        borrowOut,
  output logic        zero,
  output logic        negative,
  output logic        overflow
);

  localparam int NUM_CHUNKS = 64 / DIGIT_W;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [63:0]        a_r;
  logic [63:0]        b_r;
  logic [CW-1:0]      cnt;
  logic               borrow;
  logic               accept;
  logic               last;
  logic [DIGIT_W-1:0] a_k;
  logic [DIGIT_W-1:0] b_k;
  logic [DIGIT_W-1:0] d;
  logic               bout;
  logic [63:0]        diff_nxt;
  logic               ovf_nxt;
  int                 idx;

  // DONE accepts a new start just like IDLE
  always_comb begin
    accept = start && (state != RUN);
    last   = (state == RUN) && (cnt == LAST);
    idx    = int'(cnt) * DIGIT_W;
    a_k    = a_r[idx +: DIGIT_W];
    b_k    = b_r[idx +: DIGIT_W];
    {bout, d} = {1'b0, a_k} - {1'b0, b_k}
              - {{DIGIT_W{1'b0}}, borrow};
    diff_nxt = diff;
    diff_nxt[idx +: DIGIT_W] = d;
    ovf_nxt = (a_r[63] != b_r[63])
           && (diff_nxt[63] != a_r[63]);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrowOut <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_r    <= a;
        b_r    <= b;
        cnt    <= '0;
        borrow <= 1'b0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        diff   <= diff_nxt;
        borrow <= bout;
        cnt    <= cnt + CW'(1);
        if (last) begin
          borrowOut <= bout;
          zero      <= (diff_nxt == 64'd0);
          negative  <= diff_nxt[63];
          overflow  <= ovf_nxt;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor64.sv
// Scoreboard bench for serial_subtractor64: expected results queued
// at issue, popped and compared whenever done pulses.
module tb_serial_subtractor64;

  localparam int N = 8;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] diff;
  logic        borrowOut;
  logic        zero;
  logic        negative;
  logic        overflow;

  serial_subtractor64 #(.DIGIT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrowOut(borrowOut),
    .zero(zero),
    .negative(negative),
    .overflow(overflow)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop the oldest expected op on every done pulse
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        logic [63:0] d;
        e = q.pop_front();
        d = e.a - e.b;
        chk("diff", diff, d);
        chk("borrowOut", 64'(borrowOut), 64'(e.a < e.b));
        chk("zero", 64'(zero), 64'(d == 64'd0));
        chk("negative", 64'(negative), 64'(d[63]));
        chk("overflow", 64'(overflow),
            64'((e.a[63] != e.b[63]) && (d[63] != e.a[63])));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("latency", 64'(cyc - e.acc), 64'(N));
      end
    end
  end

  // Waits at negedges until the DUT can accept (busy low), bounded
  task automatic wait_ready();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("done_timeout", 64'd1, 64'd0);
  endtask

  // Called at a negedge with the DUT able to accept
  task automatic issue(input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    start = 1'b1;
    a = x;
    b = y;
    e.a = x;
    e.b = y;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic op(input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    wait_ready();
    issue(x, y);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    start = 1'b0;
    a = '0;
    b = '0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", 64'({borrowOut, zero, negative, overflow}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    op(64'd5, 64'd3);
    op(64'd0, 64'd1);
    op(64'h8000000000000000, 64'd1);
    op(64'h123456789ABCDEF0, 64'h123456789ABCDEF0);
    op(64'h0000000100000000, 64'd1);
    @(negedge clk);
    wait_done();
    issue(64'd2, 64'd7);
    drain();
    chk("b2b_diff", diff, 64'hFFFFFFFFFFFFFFFB);

    // start pulses and operand changes while busy must be ignored
    op(64'hDEADBEEF00000000, 64'h0000000012345678);
    repeat (3) begin
      start = 1'b1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("hold_diff", diff, 64'hDEADBEEF00000000 - 64'h12345678);

    // reset aborts an in-flight operation
    op(64'hFFFF0000FFFF0000, 64'h1111);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    q.delete();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_diff", diff, 64'd0);
    chk("abort_flags",
        64'({borrowOut, zero, negative, overflow}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    op(64'd10, 64'd4);
    drain();
    chk("post_rst_diff", diff, 64'd6);

    // random ops, some issued back-to-back in the done cycle
    for (int i = 0; i < 40; i++) begin
      logic [63:0] x;
      logic [63:0] y;
      x = {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? x : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1 && busy) begin
        wait_done();
        issue(x, y);
      end else begin
        op(x, y);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
